// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch burst front end: AXI encodings,
// AR FSM states and fetch packet layout helpers.
package fetch_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         INSTR_W        = 32;

    typedef enum logic {
        AR_IDLE,
        AR_REQ
    } ar_state_e;

    // One lane is {valid, instr, pc}; pc sits at bit 0, instr above it, valid on top.
    function automatic int lane_w(input int addr_w);
        return 1 + INSTR_W + addr_w;
    endfunction

    function automatic int lane_instr_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int lane_valid_bit(input int addr_w);
        return addr_w + INSTR_W;
    endfunction

    function automatic int fetch_w(input int data_w, input int addr_w);
        return (data_w / INSTR_W) * lane_w(addr_w) + 1;
    endfunction

endpackage

// File: rtl/fetch_beat_unpack.sv
// Splits one AXI read beat into per-lane {valid, instr, pc} fields; a lane is
// valid only when the beat is kept and its pc has not already been delivered.
module fetch_beat_unpack
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic [ADDR_W-1:0]                            beat_addr_i,
    input  logic [ADDR_W-1:0]                            fetch_pc_i,
    input  logic                                         keep_i,
    input  logic [DATA_W-1:0]                            rdata_i,
    output logic [(DATA_W/INSTR_W)*lane_w(ADDR_W)-1:0]   lanes_o,
    output logic                                         any_valid_o
);

    localparam int IPB = DATA_W / INSTR_W;
    localparam int LW  = lane_w(ADDR_W);

    logic [IPB-1:0] lane_vld;

    for (genvar i = 0; i < IPB; i++) begin : g_lane
        logic [ADDR_W-1:0] pc;
        assign pc          = beat_addr_i + ADDR_W'(4 * i);
        assign lane_vld[i] = keep_i && (pc >= fetch_pc_i);
        assign lanes_o[i*LW +: LW] = {lane_vld[i], rdata_i[i*INSTR_W +: INSTR_W], pc};
    end

    assign any_valid_o = |lane_vld;

endmodule

// File: rtl/fetch_burst_ctrl.sv
// Instruction-fetch front end: issues INCR bursts on AXI AR, unpacks returned
// beats into fetch packets and drains bursts made stale by a redirect.
module fetch_burst_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W          = 32,
    parameter int                DATA_W          = 64,
    parameter int                BURST_LEN       = 4,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                jump,
    input  logic                                jump_accept,
    input  logic [ADDR_W-1:0]                   jump_addr,
    input  logic                                stop_fetch,
    input  logic                                arready,
    output logic                                arvalid,
    output logic [ADDR_W-1:0]                   araddr,
    output logic [1:0]                          arburst,
    output logic [2:0]                          arsize,
    output logic [7:0]                          arlen,
    input  logic                                rvalid,
    input  logic                                rlast,
    input  logic [1:0]                          rresp,
    input  logic [DATA_W-1:0]                   rdata,
    output logic                                rready,
    output logic                                write_fifo,
    output logic [fetch_w(DATA_W, ADDR_W)-1:0]  fetch_packet
);

    localparam int BEAT_BYTES  = DATA_W / 8;
    localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int IDX_W       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    // In-flight total (live + draining) is held to 2*MAX_OUTSTANDING by the issue gate.
    localparam int CNT_W       = $clog2(2 * MAX_OUTSTANDING + 2);
    localparam int FW          = fetch_w(DATA_W, ADDR_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BURST_BYTES - 1);

    ar_state_e         ar_state_q;
    logic              arvalid_q;
    logic [ADDR_W-1:0] araddr_q;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] issue_addr_q, issue_addr_d;
    logic [ADDR_W-1:0] rbase_q, rbase_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  disc_q, disc_d;
    logic              stale_q, stale_d;
    logic [IDX_W-1:0]  beat_idx_q, beat_idx_d;
    logic              wr_q, wr_d;
    logic [FW-1:0]     pkt_q, pkt_d;

    logic              redirect, hs_ar, hs_r, disc_nz, issue_ok, any_valid;
    logic [ADDR_W-1:0] beat_addr;
    logic [FW-2:0]     lanes;

    assign redirect  = jump & jump_accept;
    assign hs_ar     = arvalid_q & arready;
    assign disc_nz   = (disc_q != '0);
    assign rready    = rst_n & (~stop_fetch | disc_nz);
    assign hs_r      = rvalid & rready;
    assign beat_addr = rbase_q + ADDR_W'(beat_idx_q) * ADDR_W'(BEAT_BYTES);
    assign issue_ok  = ~stop_fetch & ~redirect
                     & (outst_q < CNT_W'(MAX_OUTSTANDING))
                     & ((CNT_W+1)'(outst_q) + (CNT_W+1)'(disc_q) < (CNT_W+1)'(2 * MAX_OUTSTANDING));

    assign arvalid      = arvalid_q;
    assign araddr       = araddr_q;
    assign arburst      = AXI_BURST_INCR;
    assign arsize       = 3'($clog2(BEAT_BYTES));
    assign arlen        = 8'(BURST_LEN - 1);
    assign write_fifo   = wr_q;
    assign fetch_packet = pkt_q;

    fetch_beat_unpack #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_unpack (
        .beat_addr_i (beat_addr),
        .fetch_pc_i  (fetch_pc_q),
        .keep_i      (~disc_nz),
        .rdata_i     (rdata),
        .lanes_o     (lanes),
        .any_valid_o (any_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_state_q <= AR_IDLE;
            arvalid_q  <= 1'b0;
            araddr_q   <= RESET_PC & ALIGN_MASK;
        end else begin
            case (ar_state_q)
                AR_IDLE: if (issue_ok) begin
                    ar_state_q <= AR_REQ;
                    arvalid_q  <= 1'b1;
                    araddr_q   <= issue_addr_q;
                end
                AR_REQ: if (arready) begin
                    ar_state_q <= AR_IDLE;
                    arvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        issue_addr_d = issue_addr_q;
        rbase_d      = rbase_q;
        outst_d      = outst_q;
        disc_d       = disc_q;
        stale_d      = stale_q;
        beat_idx_d   = beat_idx_q;
        wr_d         = 1'b0;
        pkt_d        = pkt_q;

        // Beat position follows the bus even while draining so the next live burst starts at 0.
        if (hs_r) beat_idx_d = rlast ? '0 : beat_idx_q + IDX_W'(1);

        if (redirect) begin
            fetch_pc_d   = jump_addr;
            issue_addr_d = jump_addr & ALIGN_MASK;
            rbase_d      = jump_addr & ALIGN_MASK;
            outst_d      = '0;
            // A pending AR is counted for draining now, once only, and ignored at its handshake.
            disc_d       = disc_q + outst_q
                         + CNT_W'((ar_state_q == AR_REQ) && !stale_q)
                         - CNT_W'(hs_r & rlast);
            stale_d      = (ar_state_q == AR_REQ) & ~hs_ar;
        end else begin
            if (hs_ar) begin
                if (stale_q) begin
                    stale_d = 1'b0;
                end else begin
                    outst_d      = outst_d + CNT_W'(1);
                    issue_addr_d = issue_addr_q + ADDR_W'(BURST_BYTES);
                end
            end
            if (hs_r && rlast) begin
                if (disc_nz) begin
                    disc_d = disc_q - CNT_W'(1);
                end else begin
                    outst_d = outst_d - CNT_W'(1);
                    rbase_d = rbase_q + ADDR_W'(BURST_BYTES);
                end
            end
            if (hs_r && !disc_nz && any_valid) begin
                wr_d       = 1'b1;
                pkt_d      = {(rresp != AXI_RESP_OKAY), lanes};
                fetch_pc_d = beat_addr + ADDR_W'(BEAT_BYTES);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q   <= RESET_PC;
            issue_addr_q <= RESET_PC & ALIGN_MASK;
            rbase_q      <= RESET_PC & ALIGN_MASK;
            outst_q      <= '0;
            disc_q       <= '0;
            stale_q      <= 1'b0;
            beat_idx_q   <= '0;
            wr_q         <= 1'b0;
            pkt_q        <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            issue_addr_q <= issue_addr_d;
            rbase_q      <= rbase_d;
            outst_q      <= outst_d;
            disc_q       <= disc_d;
            stale_q      <= stale_d;
            beat_idx_q   <= beat_idx_d;
            wr_q         <= wr_d;
            pkt_q        <= pkt_d;
        end
    end

endmodule

// File: doc/fetch_burst_ctrl.md
# fetch_burst_ctrl

Parametrised instruction-fetch front end driving an AXI4 read master port. It issues INCR bursts of instruction lines, keeps up to MAX_OUTSTANDING bursts in flight, and unpacks each returned beat into per-lane {valid, instr, pc} packets for the fetch FIFO. On an accepted jump it redirects the fetch PC and silently drains bursts already requested. Sits between the PC/branch logic and the fetch FIFO that feeds decode.

## Interface
- ADDR_W, 32, address and PC width
- DATA_W, 64, AXI read data width; multiple of 32; INSTR_PER_BEAT = DATA_W/32
- BURST_LEN, 4, beats per burst (1..16); BURST_BYTES = BURST_LEN*DATA_W/8, power of two, ≤4096
- MAX_OUTSTANDING, 2, in-flight burst limit (1..7)
- RESET_PC, 0, fetch PC after reset

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- jump  in  1  redirect request
- jump_accept  in  1  redirect qualified; redirect occurs only when jump & jump_accept
- jump_addr  in  ADDR_W  redirect target, 4-byte aligned
- stop_fetch  in  1  fetch FIFO has at most one free entry
- arready  in  1  AXI AR ready
- arvalid  out  1  AXI AR valid
- araddr  out  ADDR_W  burst address, BURST_BYTES-aligned
- arburst  out  2  constant 2'b01 (INCR)
- arsize  out  3  constant log2(DATA_W/8)
- arlen  out  8  constant BURST_LEN-1
- rvalid  in  1  AXI R valid
- rlast  in  1  AXI R last
- rresp  in  2  AXI R response
- rdata  in  DATA_W  AXI R data
- rready  out  1  AXI R ready
- write_fifo  out  1  fetch_packet valid, one FIFO push
- fetch_packet  out  FETCH_W  FETCH_W = INSTR_PER_BEAT*(1+32+ADDR_W)+1; lane i occupies bits [i*(33+ADDR_W) +: 33+ADDR_W] as {valid, instr, pc}; MSB = fault

## Operation
- State: fetch_pc (next instruction to deliver), issue_addr (next burst address), outstanding count, discard count, beat index within current burst, AR FSM.
- AR FSM: AR_IDLE -> AR_REQ when !stop_fetch, outstanding+pending < MAX_OUTSTANDING, not in reset; araddr = issue_addr latched on entry. AR_REQ holds arvalid/araddr stable until arready; on handshake outstanding++, issue_addr += BURST_BYTES, return to AR_IDLE.
- After reset/redirect issue_addr = target aligned down to BURST_BYTES.
- R side: rready = !stop_fetch | (discard != 0). Beat handshake = rvalid & rready. Beat index counts 0..BURST_LEN-1, reset on rlast; rlast decrements outstanding (or discard if nonzero).
- Beat address = burst base + index*DATA_W/8; lane i pc = beat address + 4i, instr = rdata[32i +: 32].
- Lane valid = (discard == 0) & (lane pc ≥ fetch_pc). Beats with no valid lane produce no write. fault = (rresp != 2'b00).
- After a written beat fetch_pc = beat address + DATA_W/8.
- Redirect (jump & jump_accept): fetch_pc = jump_addr; discard += outstanding (+1 if AR_REQ pending, + that AR once handshaken); a beat handshaken the same cycle is discarded; redirect has priority over every other update. AR_REQ in progress is never withdrawn.
- No issue while discard != 0 is not required; new bursts may issue immediately from the redirect target.

## Timing
- Reset values: arvalid 0, araddr RESET_PC aligned, rready 0 during reset, write_fifo 0, fetch_packet 0, counters 0, fetch_pc RESET_PC.
- First arvalid one cycle after rst_n deasserts.
- write_fifo/fetch_packet registered: one cycle after the beat handshake, pulse for exactly one cycle per written beat.
- stop_fetch assertion blocks the next beat handshake the same cycle; the one in-flight registered write uses the slack entry.
- Reset mid-burst: all state cleared; the interconnect is reset by the same rst_n.

## Structure
- Shared package fetch_pkg: AXI burst/resp constants, lane field offsets, FETCH_W function.
- One sub-module: fetch_beat_unpack (combinational lane pc/valid/instr generation).

## Test plan
- Reset, RESET_PC=0x0, arready=1 -> AR at 0x0, arlen=3, arsize=3, arburst=01; 4 beats -> 4 writes, pcs 0x0/0x4 ... 0x18/0x1C.
- Jump to 0x104 accepted with 2 bursts outstanding -> those 8 beats produce no write; next AR at 0x100; first packet lane0 valid=0, lane1 pc=0x104 valid=1.
- stop_fetch held 5 cycles mid-burst -> rready 0, no writes, beat index preserved; resume completes burst in order.
- arready low 3 cycles -> arvalid and araddr stable; outstanding never exceeds 2.
- rresp=2'b10 on beat 2 -> that packet fault=1, others 0.
- Jump and beat handshake in same cycle -> beat discarded, fetch_pc = jump_addr.
